// File: rtl/pio_in_edge.sv
`default_nettype none
// ============================================================================
//  Module      : pio_in_edge
//  Description : Avalon-MM input PIO slave. Synchronises a WIDTH-bit
//                asynchronous input bus, exposes its level, latches per-bit
//                edges into sticky write-1-to-clear bits and drives a
//                maskable level interrupt. Read latency is one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_in_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  localparam logic [1:0] c_ADDR_DATA     = 2'd0;
  localparam logic [1:0] c_ADDR_RESERVED = 2'd1;
  localparam logic [1:0] c_ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] c_ADDR_EDGECAP  = 2'd3;

  // Edge detection stays off until the synchroniser has refilled and prev
  // has caught up, so levels present at reset release never look like edges.
  localparam int                  c_WARM_CYCLES = SYNC_STAGES + 1;
  localparam int                  c_WARM_W      = $clog2(c_WARM_CYCLES + 1);
  localparam logic [c_WARM_W-1:0] c_WARM_DONE   = c_WARM_W'(c_WARM_CYCLES);
  localparam logic [c_WARM_W-1:0] c_WARM_ONE    = c_WARM_W'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_chain;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_irqmask;
  logic [WIDTH-1:0]                  r_edgecap;
  logic [c_WARM_W-1:0]               r_warm_cnt;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_raw;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_rdata;
  logic             w_armed;
  logic             w_write;
  logic             w_wr_mask;
  logic             w_wr_ecap;

  assign w_sync    = r_sync_chain[SYNC_STAGES-1];
  assign w_rise    = w_sync & ~r_prev;
  assign w_fall    = ~w_sync & r_prev;
  assign w_armed   = (r_warm_cnt == c_WARM_DONE);
  assign w_edge    = w_armed ? w_edge_raw : '0;

  assign w_write   = chipselect & ~write_n;
  assign w_wr_mask = w_write && (address == c_ADDR_IRQMASK);
  assign w_wr_ecap = w_write && (address == c_ADDR_EDGECAP);
  assign w_clear   = w_wr_ecap ? writedata : '0;

  // Edge polarity is fixed at elaboration time.
  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge_raw = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge_raw = w_fall;
    end else begin : g_edge_any
      assign w_edge_raw = w_rise | w_fall;
    end
  endgenerate

  // Metastability chain: stage 0 samples the raw pins, last stage is sync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_chain <= '0;
    end else begin
      r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], in_port};
    end
  end

  // prev follows sync every cycle, including during warm-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_sync;
    end
  end

  // Warm-up counter saturates once edge detection is armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm_cnt <= '0;
    end else if (!w_armed) begin
      r_warm_cnt <= r_warm_cnt + c_WARM_ONE;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_wr_mask) begin
      r_irqmask <= writedata;
    end
  end

  // Sticky edge capture; a new edge overrides a same-cycle clear on that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clear) | w_edge;
    end
  end

  // Level interrupt from the registered capture and mask state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(r_edgecap & r_irqmask);
    end
  end

  // Read mux; not qualified by chipselect.
  always_comb begin
    w_rdata = '0;
    case (address)
      c_ADDR_DATA:     w_rdata = w_sync;
      c_ADDR_RESERVED: w_rdata = '0;
      c_ADDR_IRQMASK:  w_rdata = r_irqmask;
      c_ADDR_EDGECAP:  w_rdata = r_edgecap;
      default:         w_rdata = '0;
    endcase
  end

  // Registered read data gives the one-clock read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_in_edge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_in_edge
//  Description : Self-checking bench for pio_in_edge. Three instances share
//                the bus and pins (rising, falling, any-edge). Stimulus pushes
//                time-tagged expectations; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_in_edge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] in_port;

  logic [2:0][7:0] rd_v;
  logic [2:0]      irq_v;

  always #5 clk = ~clk;

  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_v[0]), .irq(irq_v[0]));

  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_v[1]), .irq(irq_v[1]));

  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_v[2]), .irq(irq_v[2]));

  typedef struct {
    int         due;
    int         inst;
    bit         is_irq;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Cycle counter used to tag when each expectation falls due.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int due, input int inst, input bit is_irq,
                      input logic [7:0] v, input string n);
    exp_t e;
    e.due = due; e.inst = inst; e.is_irq = is_irq; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic exp_rd(input int inst, input logic [7:0] v, input string n);
    push(cyc + 1, inst, 1'b0, v, n);
  endtask

  task automatic exp_irq(input int inst, input logic v, input string n);
    push(cyc + 1, inst, 1'b1, {7'b0, v}, n);
  endtask

  // Expectation for the outputs as they are right now (no clock edge).
  task automatic exp_now(input int inst, input bit is_irq, input logic [7:0] v,
                         input string n);
    push(cyc, inst, is_irq, v, n);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Monitor: compares every expectation that has fallen due.
  initial begin
    exp_t       e;
    logic [7:0] actual;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        actual = e.is_irq ? {7'b0, irq_v[e.inst]} : rd_v[e.inst];
        checks++;
        if (e.due != cyc) begin
          errors++;
          $display("FAIL %s (inst %0d): check missed its cycle", e.name, e.inst);
        end else if (actual !== e.exp) begin
          errors++;
          $display("FAIL %s (inst %0d): got %h expected %h", e.name, e.inst,
                   actual, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus. Inputs change on falling edges.
  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 8'h00; in_port = 8'hFF;

    // Input high through reset: level visible, no edge, no irq.
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    address = 2'd0;
    exp_rd(0, 8'hFF, "data_after_reset");
    tick();
    address = 2'd3;
    exp_rd(0, 8'h00, "ecap_after_reset_rise");
    exp_rd(1, 8'h00, "ecap_after_reset_fall");
    exp_rd(2, 8'h00, "ecap_after_reset_any");
    exp_irq(0, 1'b0, "irq_after_reset");
    tick();

    // All bits fall: only falling/any instances capture.
    in_port = 8'h00;
    repeat (4) tick();
    exp_rd(0, 8'h00, "fall_all_rise_inst");
    exp_rd(1, 8'hFF, "fall_all_fall_inst");
    exp_rd(2, 8'hFF, "fall_all_any_inst");
    tick();
    wr(2'd3, 8'hFF);
    wr(2'd2, 8'h04);
    address = 2'd2;
    exp_rd(0, 8'h04, "mask_readback");
    exp_irq(0, 1'b0, "irq_masked_idle");
    tick();

    // 00 -> 05, edge numbering starts at the next rising edge.
    in_port = 8'h05;
    address = 2'd3;
    exp_rd(0, 8'h00, "ecap_cleared");
    exp_rd(1, 8'h00, "ecap_cleared_fall");
    tick();
    exp_rd(0, 8'h00, "ecap_e1");
    tick();
    exp_rd(0, 8'h00, "ecap_before_e2");
    exp_irq(0, 1'b0, "irq_at_e2");
    tick();
    exp_rd(0, 8'h05, "ecap_rise_05");
    exp_rd(1, 8'h00, "ecap_no_fall");
    exp_rd(2, 8'h05, "ecap_any_05");
    exp_irq(0, 1'b1, "irq_at_e3");
    exp_irq(1, 1'b0, "irq_fall_inst");
    tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 8'h04;
    exp_rd(0, 8'h05, "ecap_pre_clear");
    exp_irq(0, 1'b1, "irq_held");
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    exp_rd(0, 8'h01, "ecap_post_clear");
    exp_irq(0, 1'b0, "irq_drop");
    tick();

    // Same-cycle edge and clear on bit 0.
    wr(2'd3, 8'hFF);
    in_port = 8'h04;
    repeat (4) tick();
    in_port = 8'h05;
    tick();
    exp_rd(1, 8'h01, "fall_bit0");
    tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 8'h01;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    exp_rd(0, 8'h01, "set_wins_rise");
    exp_rd(1, 8'h00, "clear_no_edge_fall");
    exp_rd(2, 8'h01, "set_wins_any");
    tick();

    // Bit 7 up then down across the three edge types.
    wr(2'd3, 8'hFF);
    in_port = 8'h85;
    repeat (4) tick();
    exp_rd(0, 8'h80, "b7_up_rise");
    exp_rd(1, 8'h00, "b7_up_fall");
    exp_rd(2, 8'h80, "b7_up_any");
    tick();
    wr(2'd3, 8'hFF);
    in_port = 8'h05;
    repeat (4) tick();
    exp_rd(0, 8'h00, "b7_down_rise");
    exp_rd(1, 8'h80, "b7_down_fall");
    exp_rd(2, 8'h80, "b7_down_any");
    tick();

    // Back-to-back reads of the whole map; reserved ignores writes.
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'h3C);
    address = 2'd0;
    exp_rd(0, 8'h05, "rd_seq_data");
    tick();
    address = 2'd1;
    exp_rd(0, 8'h00, "rd_seq_reserved");
    tick();
    address = 2'd2;
    exp_rd(0, 8'h3C, "rd_seq_mask");
    tick();
    address = 2'd3;
    exp_rd(0, 8'h00, "rd_seq_ecap");
    exp_rd(1, 8'h80, "rd_seq_ecap_fall");
    tick();

    // Build EDGECAP=AA with irq high, then reset asynchronously.
    wr(2'd3, 8'hFF);
    wr(2'd2, 8'hAA);
    in_port = 8'hAF;
    address = 2'd3;
    repeat (4) tick();
    exp_rd(0, 8'hAA, "ecap_aa");
    exp_irq(0, 1'b1, "irq_before_reset");
    tick();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_now(i, 1'b0, 8'h00, "rd_async_reset");
      exp_now(i, 1'b1, 8'h00, "irq_async_reset");
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_rd(0, 8'h00, "warmup_no_edge_rise");
      exp_rd(2, 8'h00, "warmup_no_edge_any");
      exp_irq(0, 1'b0, "warmup_irq");
      tick();
    end
    address = 2'd0;
    exp_rd(0, 8'hAF, "data_after_rerelease");
    tick();
    repeat (2) tick();

    if (q.size() != 0) begin
      checks += q.size();
      errors += q.size();
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
